// File: rtl/i2s_pkg.sv
// Shared definitions for the i2s transmitter path: burst size, sample format
// and the feeder FSM encoding (also used by the bench for state checks).
package i2s_pkg;

   localparam int unsigned BURST_LEN = 512;
   localparam int unsigned SAMPLE_W  = 16;
   localparam int unsigned BYTE_W    = 8;

   typedef struct packed {
      logic [BYTE_W-1:0] hi;
      logic [BYTE_W-1:0] lo;
   } pcm_sample_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PULSE   = 3'd1,
      ST_GAP     = 3'd2,
      ST_WAIT_HI = 3'd3,
      ST_WAIT_LO = 3'd4
   } feed_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and an occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot that same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full_c,
   output logic                   empty_c,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full_c  = (level == LW'(DEPTH));
   assign empty_c = (level == '0);
   assign do_pop  = pop && !empty_c;
   assign do_push = push && (!full_c || do_pop);

   // Storage array carries no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         rdata  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            rdata  <= mem[rd_ptr];
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/pcm_byte_feeder.sv
// Packs UART bytes into 16-bit PCM samples (low byte first), buffers them and
// loads the i2s transmitter memory in bursts over the init/dta/busy handshake.
module pcm_byte_feeder
   import i2s_pkg::*;
#(
   parameter int unsigned BURST      = BURST_LEN,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [BYTE_W-1:0]           rx_data,
   input  logic                        rx_valid,
   output logic [SAMPLE_W-1:0]         dta,
   output logic                        init,
   input  logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        overrun,
   output logic                        bursting
);

   localparam int unsigned WCW = $clog2(BURST);

   feed_state_t       state;
   feed_state_t       state_nx;
   logic [WCW-1:0]    wcnt;
   logic [WCW-1:0]    wcnt_nx;
   logic              half;
   logic [BYTE_W-1:0] low_byte;
   pcm_sample_t       push_word;
   logic              push_c;
   logic              pop_c;
   logic              full_c;
   logic              empty_c;

   // Byte packer: first byte of a pair is held, second completes the sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half     <= 1'b0;
         low_byte <= '0;
      end else if (rx_valid) begin
         half <= ~half;
         if (!half) low_byte <= rx_data;
      end
   end

   assign push_c    = rx_valid && half;
   assign push_word = {rx_data, low_byte};

   // The FIFO read register doubles as the dta output register
   sync_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push_c),
      .wdata   (push_word),
      .pop     (pop_c),
      .rdata   (dta),
      .full_c  (full_c),
      .empty_c (empty_c),
      .level   (level)
   );

   // Burst loader: IDLE->PULSE->GAP per word, then wait for the buffer to play out
   always_comb begin
      state_nx = state;
      wcnt_nx  = wcnt;
      pop_c    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty_c && !busy) begin
               pop_c    = 1'b1;
               state_nx = ST_PULSE;
            end
         end
         ST_PULSE: begin
            if (wcnt == WCW'(BURST - 1)) begin
               wcnt_nx  = '0;
               state_nx = ST_WAIT_HI;
            end else begin
               wcnt_nx  = wcnt + 1'b1;
               state_nx = ST_GAP;
            end
         end
         ST_GAP:     state_nx = ST_IDLE;
         ST_WAIT_HI: if (busy)  state_nx = ST_WAIT_LO;
         ST_WAIT_LO: if (!busy) state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         wcnt     <= '0;
         init     <= 1'b0;
         bursting <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nx;
         wcnt     <= wcnt_nx;
         init     <= (state_nx == ST_PULSE);
         bursting <= (wcnt_nx != '0) || (state_nx != ST_IDLE);
         if (push_c && full_c && !pop_c) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pcm_byte_feeder.sv
// Scoreboard bench for pcm_byte_feeder against a small i2s buffer model:
// stimulus queues expected samples, a monitor checks every init pulse.
module tb_pcm_byte_feeder;
   import i2s_pkg::*;

   localparam int unsigned BURST      = 512;
   localparam int unsigned FIFO_DEPTH = 16;
   localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1;
   localparam int          PLAY       = 40;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic [15:0]   dta;
   logic          init;
   logic          busy;
   logic [LW-1:0] level;
   logic          overrun;
   logic          bursting;

   logic          model_busy;
   logic          force_busy = 1'b0;
   logic          init_d;
   int            wptr;
   int            play;
   logic [15:0]   model_mem [BURST];

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [15:0]   exp_q [$];
   int            pulse_cnt = 0;
   logic          init_prev = 1'b0;
   bit            saw_hi = 1'b0;
   bit            saw_lo = 1'b0;

   always #5 clk = ~clk;

   assign busy = model_busy | force_busy;

   pcm_byte_feeder #(
      .BURST      (BURST),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .dta      (dta),
      .init     (init),
      .busy     (busy),
      .level    (level),
      .overrun  (overrun),
      .bursting (bursting)
   );

   // i2s buffer model: captures dta on init rising, busy after a full buffer
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_busy <= 1'b0;
         init_d     <= 1'b0;
         wptr       <= 0;
         play       <= 0;
      end else begin
         init_d <= init;
         if (init && !init_d && !model_busy) begin
            model_mem[wptr] <= dta;
            if (wptr == BURST - 1) begin
               model_busy <= 1'b1;
               play       <= PLAY;
               wptr       <= 0;
            end else begin
               wptr <= wptr + 1;
            end
         end else if (model_busy) begin
            if (play == 0) model_busy <= 1'b0;
            else           play <= play - 1;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Monitor: every init pulse must carry the next queued sample
   always @(negedge clk) begin
      if (rst) begin
         init_prev = 1'b0;
      end else begin
         if (init) begin
            pulse_cnt++;
            check("init_gap", int'(init_prev), 0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_init: got pulse with dta 0x%h, expected no pulse", dta);
            end else begin
               logic [15:0] e;
               e = exp_q.pop_front();
               check("dta", int'(dta), int'(e));
            end
         end
         init_prev = init;
         if (dut.state == ST_WAIT_HI) saw_hi = 1'b1;
         if (dut.state == ST_WAIT_LO && saw_hi) saw_lo = 1'b1;
      end
   end

   task automatic do_reset();
      rst        = 1'b1;
      rx_valid   = 1'b0;
      force_busy = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      pulse_cnt = 0;
      saw_hi    = 1'b0;
      saw_lo    = 1'b0;
      rst       = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_sample(input logic [15:0] w, input bit expect_it);
      if (expect_it) exp_q.push_back(w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
   endtask

   task automatic wait_drain(input int max);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_model(input logic val, input int max, input string name);
      int n;
      n = 0;
      while (model_busy !== val && n < max) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(model_busy), int'(val));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int bad;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_init", int'(init), 0);
      check("rst_dta", int'(dta), 0);
      check("rst_level", int'(level), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_bursting", int'(bursting), 0);
      check("rst_state", int'(dut.state), int'(ST_IDLE));
      rst = 1'b0;

      // Byte packing: 0x34 then 0x12; init in the third cycle counting the strobe cycle
      do_reset();
      exp_q.push_back(16'h1234);
      send_byte(8'h34);
      @(negedge clk);
      rx_data  = 8'h12;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      check("pack_level", int'(level), 1);
      check("pack_init_early", int'(init), 0);
      @(negedge clk);
      check("pack_init", int'(init), 1);
      check("pack_dta", int'(dta), 16'h1234);
      @(negedge clk);
      check("pack_gap", int'(init), 0);
      check("pack_level_empty", int'(level), 0);

      // Full burst of 0..511 plus one extra word held back by busy
      do_reset();
      fork
         begin
            for (int i = 0; i <= BURST; i++) send_sample(16'(i), 1'b1);
         end
         begin
            wait_model(1'b1, 5000, "burst_busy_rise");
            check("burst_pulses", pulse_cnt, BURST);
            bad = 0;
            for (int i = 0; i < BURST; i++)
               if (model_mem[i] !== 16'(i)) bad++;
            check("burst_mem_bad", bad, 0);
            wait_model(1'b0, 500, "burst_busy_fall");
            check("no_word_during_busy", pulse_cnt, BURST);
         end
      join
      wait_drain(100);
      check("word_after_busy", pulse_cnt, BURST + 1);
      check("saw_wait_hi", int'(saw_hi), 1);
      check("saw_wait_lo", int'(saw_lo), 1);

      // Overrun: 17 samples while busy; the 17th is dropped
      do_reset();
      force_busy = 1'b1;
      for (int i = 0; i < 17; i++) send_sample(16'(16'hA000 + i), i < 16);
      repeat (2) @(negedge clk);
      check("ovr_level", int'(level), FIFO_DEPTH);
      check("ovr_flag", int'(overrun), 1);
      check("ovr_no_pulse", pulse_cnt, 0);
      force_busy = 1'b0;
      wait_drain(200);
      check("ovr_pulses", pulse_cnt, 16);
      check("ovr_level_empty", int'(level), 0);
      check("ovr_sticky", int'(overrun), 1);

      // Empty FIFO mid-burst: 100 words, long pause, then the remaining 412
      do_reset();
      for (int i = 0; i < 100; i++) send_sample(16'(16'h4000 + i), 1'b1);
      wait_drain(100);
      repeat (1000) @(negedge clk);
      check("gap_wcnt", int'(dut.wcnt), 100);
      check("gap_bursting", int'(bursting), 1);
      check("gap_pulses", pulse_cnt, 100);
      check("gap_state", int'(dut.state), int'(ST_IDLE));
      for (int i = 100; i < BURST; i++) send_sample(16'(16'h4000 + i), 1'b1);
      wait_model(1'b1, 50, "gap_busy_rise");
      check("gap_total_pulses", pulse_cnt, BURST);
      wait_model(1'b0, 200, "gap_busy_fall");
      repeat (3) @(negedge clk);
      check("gap_bursting_end", int'(bursting), 0);
      check("gap_wcnt_end", int'(dut.wcnt), 0);

      // Simultaneous push and pop with level 1
      do_reset();
      force_busy = 1'b1;
      send_sample(16'h1111, 1'b1);
      send_byte(8'h22);
      exp_q.push_back(16'h3322);
      check("pp_pre_level", int'(level), 1);
      @(negedge clk);
      rx_data    = 8'h33;
      rx_valid   = 1'b1;
      force_busy = 1'b0;
      @(negedge clk);
      rx_valid = 1'b0;
      check("pp_level", int'(level), 1);
      check("pp_overrun", int'(overrun), 0);
      check("pp_init", int'(init), 1);
      wait_drain(50);

      // Async reset mid-PULSE with a half-received byte pair
      do_reset();
      send_sample(16'h0101, 1'b1);
      wait_drain(50);
      force_busy = 1'b1;
      send_sample(16'hBEEF, 1'b1);
      send_byte(8'hEE);
      @(negedge clk);
      force_busy = 1'b0;
      @(negedge clk);
      check("ar_in_pulse", int'(init), 1);
      check("ar_wcnt_pre", int'(dut.wcnt), 1);
      #2 rst = 1'b1;
      #1;
      check("ar_init_drop", int'(init), 0);
      check("ar_wcnt", int'(dut.wcnt), 0);
      check("ar_bursting", int'(bursting), 0);
      @(negedge clk);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      send_sample(16'h5A3C, 1'b1);
      wait_drain(50);
      check("ar_post_wcnt", int'(dut.wcnt), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
